// File: rtl/prog_clock_divider_pkg.sv
// Shared defaults and channel state encoding for the programmable clock divider.
package prog_clock_divider_pkg;

    localparam int CNT_WIDTH_DEF   = 16;
    localparam int DEFAULT_DIV_DEF = 13312;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

endpackage

// File: rtl/prog_clock_divider_channel.sv
// One divider channel: active/shadow divisor, phase counter, registered clock_out and tick.
module clock_divider_channel
    import prog_clock_divider_pkg::*;
#(
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic                 clock_in,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 sync,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_value,
    output logic                 clock_out,
    output logic                 tick,
    output logic                 load_pending
);

    localparam logic [CNT_WIDTH-1:0] DEF_DIV = CNT_WIDTH'(DEFAULT_DIV);
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

    ch_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] div_q, div_d;
    logic [CNT_WIDTH-1:0] shadow_q, shadow_d;
    logic                 pend_q, pend_d;
    logic                 co_d, tick_d;
    logic                 boundary;
    logic [CNT_WIDTH-1:0] high_len;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        shadow_d = load ? load_value : shadow_q;
        pend_d   = pend_q;
        co_d     = 1'b0;
        tick_d   = 1'b0;
        boundary = 1'b0;
        high_len = '0;
        if (!enable) begin
            // Going idle: any waiting divisor becomes active right away.
            state_d = CH_IDLE;
            cnt_d   = '0;
            pend_d  = 1'b0;
            div_d   = load ? load_value : (pend_q ? shadow_q : div_q);
        end else begin
            state_d  = CH_RUN;
            // D of 0 or 1 wraps every cycle; the guard keeps div_q-1 from underflowing.
            boundary = (state_q == CH_IDLE) || sync || (div_q <= ONE) ||
                       (cnt_q >= div_q - ONE);
            if (state_q == CH_IDLE) begin
                div_d  = load ? load_value : div_q;
                pend_d = 1'b0;
            end else begin
                if (boundary && pend_q)
                    div_d = shadow_q;
                pend_d = load || (pend_q && !boundary);
            end
            cnt_d    = boundary ? '0 : cnt_q + ONE;
            high_len = (div_d >> 1) + CNT_WIDTH'(div_d[0]);
            co_d     = (div_d != '0) && (cnt_d < high_len);
            tick_d   = (div_d != '0) && boundary;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= CH_IDLE;
            cnt_q     <= '0;
            div_q     <= DEF_DIV;
            shadow_q  <= DEF_DIV;
            pend_q    <= 1'b0;
            clock_out <= 1'b0;
            tick      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            shadow_q  <= shadow_d;
            pend_q    <= pend_d;
            clock_out <= co_d;
            tick      <= tick_d;
        end
    end

    assign load_pending = pend_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider: divisor write decode and sync fan-out.
module prog_clock_divider
    import prog_clock_divider_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clock_in,
    input  logic                 reset_n,
    input  logic [NUM_CH-1:0]    enable,
    input  logic                 div_load,
    input  logic [CH_W-1:0]      div_ch,
    input  logic [CNT_WIDTH-1:0] div_value,
    input  logic                 sync,
    output logic [NUM_CH-1:0]    clock_out,
    output logic [NUM_CH-1:0]    tick,
    output logic [NUM_CH-1:0]    load_pending
);

    logic [NUM_CH-1:0] ch_load;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Out-of-range channel indices match no instance and are dropped.
        assign ch_load[i] = div_load && (div_ch == CH_W'(i));

        clock_divider_channel #(
            .CNT_WIDTH   (CNT_WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clock_in     (clock_in),
            .reset_n      (reset_n),
            .enable       (enable[i]),
            .sync         (sync),
            .load         (ch_load[i]),
            .load_value   (div_value),
            .clock_out    (clock_out[i]),
            .tick         (tick[i]),
            .load_pending (load_pending[i])
        );
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Scoreboard bench for prog_clock_divider: directed cycles push expectations, a monitor compares.
module tb_prog_clock_divider;

    localparam int NCH = 3;

    logic            clock_in = 1'b0;
    logic            reset_n;
    logic [NCH-1:0]  enable;
    logic            div_load;
    logic [1:0]      div_ch;
    logic [15:0]     div_value;
    logic            sync;
    logic [NCH-1:0]  clock_out, tick, load_pending;

    typedef struct {
        int             id;
        logic [NCH-1:0] co;
        logic [NCH-1:0] tk;
        logic [NCH-1:0] lp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step   = 0;

    prog_clock_divider #(.NUM_CH(NCH), .CNT_WIDTH(16), .DEFAULT_DIV(13312)) dut (
        .clock_in     (clock_in),
        .reset_n      (reset_n),
        .enable       (enable),
        .div_load     (div_load),
        .div_ch       (div_ch),
        .div_value    (div_value),
        .sync         (sync),
        .clock_out    (clock_out),
        .tick         (tick),
        .load_pending (load_pending)
    );

    always #5 clock_in = ~clock_in;

    task automatic chk(input string nm, input int id, input logic [NCH-1:0] act,
                       input logic [NCH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %b want %b", nm, id, act, exp);
        end
    endtask

    // Monitor: every output sample after a clock edge is matched against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock_in);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("clock_out", e.id, clock_out, e.co);
                chk("tick", e.id, tick, e.tk);
                chk("load_pending", e.id, load_pending, e.lp);
            end
        end
    end

    task automatic cyc(input logic [NCH-1:0] co, input logic [NCH-1:0] tk,
                       input logic [NCH-1:0] lp);
        exp_t e;
        e.id = step; e.co = co; e.tk = tk; e.lp = lp;
        exp_q.push_back(e);
        step++;
        @(posedge clock_in);
        @(negedge clock_in);
        div_load = 1'b0;
        sync     = 1'b0;
    endtask

    task automatic ld(input logic [1:0] ch, input logic [15:0] val);
        div_load  = 1'b1;
        div_ch    = ch;
        div_value = val;
    endtask

    initial begin
        reset_n = 1'b0; enable = '0; div_load = 1'b0; div_ch = '0;
        div_value = '0; sync = 1'b0;
        @(negedge clock_in);
        cyc(3'b000, 3'b000, 3'b000);
        cyc(3'b000, 3'b000, 3'b000);
        reset_n = 1'b1;
        // Idle loads take effect at once.
        ld(2'd0, 16'd4); cyc(3'b000, 3'b000, 3'b000);
        ld(2'd1, 16'd5); cyc(3'b000, 3'b000, 3'b000);
        // ch0 D=4 (1100), ch1 D=5 (11100)
        enable = 3'b011;
        cyc(3'b011, 3'b011, 3'b000);
        cyc(3'b011, 3'b000, 3'b000);
        cyc(3'b010, 3'b000, 3'b000);
        cyc(3'b000, 3'b000, 3'b000);
        cyc(3'b001, 3'b001, 3'b000);
        cyc(3'b011, 3'b010, 3'b000);
        cyc(3'b010, 3'b000, 3'b000);
        cyc(3'b010, 3'b000, 3'b000);
        cyc(3'b001, 3'b001, 3'b000);
        cyc(3'b001, 3'b000, 3'b000);
        // ch0 gets 6 mid-period; current period still ends at 4.
        ld(2'd0, 16'd6); cyc(3'b010, 3'b010, 3'b001);
        cyc(3'b010, 3'b000, 3'b001);
        cyc(3'b011, 3'b001, 3'b000);
        cyc(3'b001, 3'b000, 3'b000);
        cyc(3'b001, 3'b000, 3'b000);
        cyc(3'b010, 3'b010, 3'b000);
        cyc(3'b010, 3'b000, 3'b000);
        cyc(3'b010, 3'b000, 3'b000);
        // ch1: 7 overwritten by 3 before its boundary.
        ld(2'd1, 16'd7); cyc(3'b001, 3'b001, 3'b010);
        ld(2'd1, 16'd3); cyc(3'b001, 3'b000, 3'b010);
        cyc(3'b011, 3'b010, 3'b000);
        cyc(3'b010, 3'b000, 3'b000);
        cyc(3'b000, 3'b000, 3'b000);
        // ch1: load on its boundary waits one more period.
        ld(2'd1, 16'd2); cyc(3'b010, 3'b010, 3'b010);
        cyc(3'b011, 3'b001, 3'b010);
        cyc(3'b001, 3'b000, 3'b010);
        cyc(3'b011, 3'b010, 3'b000);
        cyc(3'b000, 3'b000, 3'b000);
        cyc(3'b010, 3'b010, 3'b000);
        // sync realigns drifted ch0/ch1; idle ch2 stays low.
        sync = 1'b1; cyc(3'b011, 3'b011, 3'b000);
        cyc(3'b001, 3'b000, 3'b000);
        // ch2: D=0 holds low, then D=1 holds high with tick every cycle.
        ld(2'd2, 16'd0); cyc(3'b011, 3'b010, 3'b000);
        enable = 3'b111; cyc(3'b000, 3'b000, 3'b000);
        ld(2'd2, 16'd1); cyc(3'b010, 3'b010, 3'b100);
        cyc(3'b100, 3'b100, 3'b000);
        cyc(3'b111, 3'b111, 3'b000);
        cyc(3'b101, 3'b100, 3'b000);
        // Out-of-range channel index is ignored.
        ld(2'd3, 16'd1); cyc(3'b111, 3'b110, 3'b000);
        enable = 3'b110; cyc(3'b100, 3'b100, 3'b000);
        ld(2'd1, 16'd9); cyc(3'b110, 3'b110, 3'b010);
        // Async reset mid-period with a pending load.
        reset_n = 1'b0;
        #1;
        chk("rst_clock_out", step, clock_out, 3'b000);
        chk("rst_tick", step, tick, 3'b000);
        chk("rst_load_pending", step, load_pending, 3'b000);
        cyc(3'b000, 3'b000, 3'b000);
        // Divisors back at 13312: long high phase on both restarted channels.
        reset_n = 1'b1; enable = 3'b011;
        cyc(3'b011, 3'b011, 3'b000);
        repeat (20) cyc(3'b011, 3'b000, 3'b000);
        // sync together with ch2 enable rising: a single restart.
        enable = 3'b111; sync = 1'b1; cyc(3'b111, 3'b111, 3'b000);
        cyc(3'b111, 3'b000, 3'b000);
        cyc(3'b111, 3'b000, 3'b000);
        @(posedge clock_in);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_clock_divider.md
PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of divisor and per-channel counter.
REQ-003 SHALL have parameter DEFAULT_DIV, default 13312, divisor every channel holds after reset.
REQ-004 SHALL have port clock_in, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port enable, input, NUM_CH, per-channel run enable.
REQ-007 SHALL have port div_load, input, 1, one-cycle write strobe for a new divisor.
REQ-008 SHALL have port div_ch, input, $clog2(NUM_CH) (min 1), channel index for div_load.
REQ-009 SHALL have port div_value, input, CNT_WIDTH, divisor written on div_load.
REQ-010 SHALL have port sync, input, 1, one-cycle phase-realign strobe for all running channels.
REQ-011 SHALL have port clock_out, output, NUM_CH, registered divided clock per channel.
REQ-012 SHALL have port tick, output, NUM_CH, registered one-cycle pulse marking each period start.
REQ-013 SHALL have port load_pending, output, NUM_CH, high while a written divisor awaits its period boundary.

Function
REQ-014 Each channel SHALL keep an active divisor D, a shadow divisor, and a counter cnt cycling 0..D-1.
REQ-015 Channel states SHALL be IDLE (enable=0) and RUN (enable=1); any edge sampling enable=0 forces IDLE with cnt=0, clock_out=0, tick=0.
REQ-016 On the first edge sampling enable=1 from IDLE, the channel SHALL enter RUN with phase 0: clock_out=1, tick=1.
REQ-017 In RUN, the k-th edge after entry SHALL present phase p = k mod D: clock_out=1 iff p < ceil(D/2), tick=1 iff p=0.
REQ-018 Duty SHALL be ceil(D/2) high and floor(D/2) low clock_in cycles per period.
REQ-019 div_load SHALL write div_value into the shadow of channel div_ch and set its load_pending on the next edge; div_ch >= NUM_CH SHALL be ignored.
REQ-020 A shadow divisor SHALL become active only at the next period boundary (the edge producing p=0), or immediately if the channel is IDLE; load_pending SHALL clear on the same edge.
REQ-021 A second div_load to the same channel before the boundary SHALL overwrite the shadow; only the last value takes effect.
REQ-022 div_load coinciding with a boundary SHALL apply the new value at the following boundary, not the current one.
REQ-023 D=0 SHALL hold clock_out=0 and tick=0 while RUN; D=1 SHALL hold clock_out=1 with tick=1 every cycle.
REQ-024 sync SHALL force every RUN channel to phase 0 on the next edge (clock_out=1, tick=1), applying any pending shadow; IDLE channels are unaffected.
REQ-025 sync and enable rising on the same edge SHALL yield the phase-0 behaviour exactly once, not a double restart.
REQ-026 Counter arithmetic SHALL be unsigned CNT_WIDTH bits, compare cnt >= D-1 for wrap so no value overflows.

Reset
REQ-027 reset_n low SHALL asynchronously set all cnt=0, active and shadow divisors=DEFAULT_DIV, clock_out=0, tick=0, load_pending=0.
REQ-028 Reset asserted mid-period SHALL discard pending loads; after release each channel restarts per REQ-016.
REQ-029 Deassertion SHALL be assumed synchronised upstream; no internal reset synchroniser.

Structure
REQ-030 Shared package prog_clock_divider_pkg SHALL hold DEFAULT_DIV, CNT_WIDTH default and the IDLE/RUN state encoding.
REQ-031 One channel SHALL be a sub-module clock_divider_channel, instantiated NUM_CH times via generate; the top holds only write decode and sync fan-out.

Verification
REQ-032 D=4, enable high -> clock_out 1,1,0,0 repeating, tick on every 4th edge starting at the first.
REQ-033 D=5 -> clock_out 1,1,1,0,0; low-time 2 cycles, high-time 3.
REQ-034 Running D=4, div_load 6 at phase 1 -> load_pending high, current period completes at 4, next period is 6 (1,1,1,0,0,0), load_pending clears at that boundary.
REQ-035 Channels 0/1 at D=6/D=3 drifted, sync pulse -> both show tick=1, clock_out=1 on the next edge.
REQ-036 div_value 0 then 1 -> clock_out held 0 with no tick, then held 1 with tick every cycle.
REQ-037 reset_n asserted mid-period with a pending load -> outputs 0 immediately, divisor reverts to 13312, load_pending 0.
